// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port memory arbiter (port 0 = CPU, port 1 = DMA/IO).
//                Latches the winning request in IDLE and drives a single memory
//                access while in BUSYx. The access ends on memReady or on a
//                wait-cycle timeout, and the requester gets a one-cycle ack in
//                DONE, with rdata/err valid in that cycle.
//                Build option MEM_ARB_RR_EN selects round-robin arbitration.
//                Without it, port 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int M       = 16,   // data bus width
    parameter int N       = 32,   // address bus width
    parameter int TIMEOUT = 15    // max memReady wait cycles (1..255)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         we0,
    input  logic [N-1:0] addr0,
    input  logic [M-1:0] wdata0,
    output logic         ack0,
    input  logic         req1,
    input  logic         we1,
    input  logic [N-1:0] addr1,
    input  logic [M-1:0] wdata1,
    output logic         ack1,
    output logic [M-1:0] rdata,
    output logic         err,
    output logic [N-1:0] memAddr,
    output logic [M-1:0] memWrite,
    input  logic [M-1:0] memRead,
    output logic         memRE,
    output logic         memWE,
    input  logic         memReady
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY0 = 2'd1;
    localparam logic [1:0] S_BUSY1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [1:0]   r_state;
    logic [7:0]   r_cnt;
    logic         r_port;     // port being served (0 or 1)
    logic         r_we;
    logic [N-1:0] r_addr;
    logic [M-1:0] r_wdata;
    logic [M-1:0] r_rdata;
    logic         r_err;

    logic         w_grant1;   // 1: port 1 wins this IDLE cycle
    logic         w_busy;

`ifdef MEM_ARB_RR_EN
    logic         r_last;     // port served by the most recent DONE

    // Remember which port completed last so contention alternates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_last <= r_port;
        end
    end

    // On contention, the port not served last wins.
    assign w_grant1 = req1 && (!req0 || !r_last);
`else
    // Fixed priority: port 0 always wins on contention.
    assign w_grant1 = req1 && !req0;
`endif

    assign w_busy = (r_state == S_BUSY0) || (r_state == S_BUSY1);

    // Main controller: request capture, memory wait/timeout, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_port  <= w_grant1;
                        r_we    <= w_grant1 ? we1    : we0;
                        r_addr  <= w_grant1 ? addr1  : addr0;
                        r_wdata <= w_grant1 ? wdata1 : wdata0;
                        r_cnt   <= 8'd0;
                        r_state <= w_grant1 ? S_BUSY1 : S_BUSY0;
                    end
                end
                S_BUSY0, S_BUSY1: begin
                    // A ready memory wins over a timeout in the same cycle.
                    if (memReady) begin
                        if (!r_we) begin
                            r_rdata <= memRead;
                        end
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from state only, so reset clears them without waiting for a clock.
    assign ack0     = (r_state == S_DONE) && !r_port;
    assign ack1     = (r_state == S_DONE) &&  r_port;
    assign memRE    = w_busy && !r_we;
    assign memWE    = w_busy &&  r_we;
    assign memAddr  = w_busy ? r_addr  : '0;
    assign memWrite = w_busy ? r_wdata : '0;
    assign rdata    = r_rdata;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Per-cycle vector table
//                for single reads/writes and contention, followed by directed
//                timeout and mid-transaction reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int M = 16;
    localparam int N = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [N-1:0] addr0 = '0, addr1 = '0;
    logic [M-1:0] wdata0 = '0, wdata1 = '0;
    logic         ack0, ack1, err, memRE, memWE;
    logic [M-1:0] rdata, memWrite;
    logic [M-1:0] memRead = '0;
    logic [N-1:0] memAddr;
    logic         memReady = 1'b0;

    int checks = 0;
    int errors = 0;
    int both_acks = 0;

    mem_arbiter #(.M(M), .N(N), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err),
        .memAddr(memAddr), .memWrite(memWrite), .memRead(memRead),
        .memRE(memRE), .memWE(memWE), .memReady(memReady)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack0 && ack1) both_acks++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         req0, we0;
        logic [N-1:0] addr0;
        logic [M-1:0] wd0;
        logic         req1, we1;
        logic [N-1:0] addr1;
        logic [M-1:0] wd1;
        logic         rdy;
        logic [M-1:0] mrd;
        logic         e_ack0, e_ack1, e_re, e_we;
        logic [N-1:0] e_maddr;
        logic [M-1:0] e_mwr;
        logic [M-1:0] e_rdata;
        logic         e_err;
    } vec_t;

    vec_t vec [19];

    function automatic vec_t mk(
        input logic r0, w0, input logic [N-1:0] a0, input logic [M-1:0] d0,
        input logic r1, w1, input logic [N-1:0] a1, input logic [M-1:0] d1,
        input logic rdy, input logic [M-1:0] mrd,
        input logic k0, k1, re, we, input logic [N-1:0] ma,
        input logic [M-1:0] mw, input logic [M-1:0] rd, input logic e);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wd0 = d0;
        v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wd1 = d1;
        v.rdy = rdy; v.mrd = mrd;
        v.e_ack0 = k0; v.e_ack1 = k1; v.e_re = re; v.e_we = we;
        v.e_maddr = ma; v.e_mwr = mw; v.e_rdata = rd; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int idx;
        int nre;
        bit found;

        // Single read (ack in cycle 3), single write with 4 wait cycles (ack in cycle 7).
        vec[0]  = mk(1,0,32'h1234,0, 0,0,0,0,      1,16'hBEEF, 0,0,0,0,0,0,16'h0,0);
        vec[1]  = mk(1,0,32'h1234,0, 0,0,0,0,      1,16'hBEEF, 0,0,1,0,32'h1234,0,16'h0,0);
        vec[2]  = mk(0,0,0,0,        0,0,0,0,      1,16'hBEEF, 1,0,0,0,0,0,16'hBEEF,0);
        vec[3]  = mk(0,0,0,0, 1,1,32'hD000,16'h55AA, 0,0,      0,0,0,0,0,0,16'hBEEF,0);
        for (int i = 4; i < 8; i++)
            vec[i] = mk(0,0,0,0, 1,1,32'hD000,16'h55AA, 0,0, 0,0,0,1,32'hD000,16'h55AA,16'hBEEF,0);
        vec[8]  = mk(0,0,0,0, 1,1,32'hD000,16'h55AA, 1,0, 0,0,0,1,32'hD000,16'h55AA,16'hBEEF,0);
        vec[9]  = mk(0,0,0,0, 0,0,0,0,               0,0, 0,1,0,0,0,0,16'hBEEF,0);
        // Both ports held: pointer is 1 here, so port 0 wins first in both modes.
        vec[10] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h2222, 0,0,0,0,0,0,16'hBEEF,0);
        vec[11] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h2222, 0,0,1,0,32'h10,0,16'hBEEF,0);
        vec[12] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h2222, 1,0,0,0,0,0,16'h2222,0);
        vec[13] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h2222, 0,0,0,0,0,0,16'h2222,0);
        vec[14] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h2222,
                     0,0,!RR,RR, RR ? 32'h20 : 32'h10, RR ? 16'h1111 : 16'h0, 16'h2222,0);
        vec[15] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h2222, !RR,RR,0,0,0,0,16'h2222,0);
        vec[16] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h3333, 0,0,0,0,0,0,16'h2222,0);
        vec[17] = mk(1,0,32'h10,0, 1,1,32'h20,16'h1111, 1,16'h3333, 0,0,1,0,32'h10,0,16'h2222,0);
        vec[18] = mk(0,0,0,0,      0,0,0,0,             1,16'h3333, 1,0,0,0,0,0,16'h3333,0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset ack0", ack0, 0);
        chk("reset ack1", ack1, 0);
        chk("reset memRE", memRE, 0);
        chk("reset memWE", memWE, 0);
        chk("reset memAddr", memAddr, 0);
        chk("reset rdata", rdata, 0);
        chk("reset err", err, 0);
        rst = 1'b0;

        // Table: drive inputs on the falling edge, check the Moore outputs.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req0 = vec[i].req0; we0 = vec[i].we0; addr0 = vec[i].addr0; wdata0 = vec[i].wd0;
            req1 = vec[i].req1; we1 = vec[i].we1; addr1 = vec[i].addr1; wdata1 = vec[i].wd1;
            memReady = vec[i].rdy; memRead = vec[i].mrd;
            #1;
            chk($sformatf("row%0d ack0", i),     ack0,     vec[i].e_ack0);
            chk($sformatf("row%0d ack1", i),     ack1,     vec[i].e_ack1);
            chk($sformatf("row%0d memRE", i),    memRE,    vec[i].e_re);
            chk($sformatf("row%0d memWE", i),    memWE,    vec[i].e_we);
            chk($sformatf("row%0d memAddr", i),  memAddr,  vec[i].e_maddr);
            chk($sformatf("row%0d memWrite", i), memWrite, vec[i].e_mwr);
            chk($sformatf("row%0d rdata", i),    rdata,    vec[i].e_rdata);
            chk($sformatf("row%0d err", i),      err,      vec[i].e_err);
        end

        // Timeout: memReady held low, ack on the 17th cycle counting BUSY entry as 1.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 32'h40; memReady = 0; memRead = 16'h9999;
        idx = 0; nre = 0; found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            #1;
            if (memRE) nre++;
            if (memRE || idx > 0) idx++;
            if (ack0) found = 1;
        end
        chk("timeout ack seen", found, 1);
        chk("timeout ack cycle", idx, 17);
        chk("timeout memRE cycles", nre, 16);
        chk("timeout err", err, 1);
        chk("timeout rdata", rdata, 0);
        req0 = 0;

        // Next transaction clears err.
        @(negedge clk);
        req0 = 1; addr0 = 32'h44; memReady = 1; memRead = 16'hABCD;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("post-timeout ack0", ack0, 1);
        chk("post-timeout err", err, 0);
        chk("post-timeout rdata", rdata, 16'hABCD);
        req0 = 0;

        // Reset during BUSY0: enables drop immediately, no ack, rdata cleared.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 32'h80; memReady = 0;
        @(negedge clk);
        #1;
        chk("pre-rst memRE", memRE, 1);
        #2;
        rst = 1;
        #1;
        chk("async rst memRE", memRE, 0);
        chk("async rst memWE", memWE, 0);
        chk("async rst memAddr", memAddr, 0);
        chk("async rst rdata", rdata, 0);
        chk("async rst err", err, 0);
        req0 = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst no ack0 %0d", c), ack0, 0);
        end
        rst = 0;

        // First request after reset is served normally.
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 32'h90; memReady = 1; memRead = 16'h7777;
        #1;
        chk("after rst idle ack1", ack1, 0);
        @(negedge clk);
        #1;
        chk("after rst memRE", memRE, 1);
        chk("after rst memAddr", memAddr, 32'h90);
        @(negedge clk);
        #1;
        chk("after rst ack1", ack1, 1);
        chk("after rst ack0", ack0, 0);
        chk("after rst rdata", rdata, 16'h7777);
        req1 = 0;
        @(negedge clk);
        #1;
        chk("ack1 single cycle", ack1, 0);

        chk("acks never simultaneous", both_acks, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
